// File: rtl/div_recon_pkg.sv
// Shared types and width helpers for the divider result reconstructor.
package div_recon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      SQR  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int W_DEF   = 8;
   localparam int NW      = 2*W_DEF;
   localparam int EW      = 2*W_DEF + 1;
   localparam int SW      = 4*W_DEF;
   localparam int MUL_CYC = W_DEF;
   localparam int SQR_CYC = 2*W_DEF;

   function automatic int nw_of(input int w);
      return 2*w;
   endfunction

   function automatic int ew_of(input int w);
      return 2*w + 1;
   endfunction

   function automatic int sw_of(input int w);
      return 4*w;
   endfunction

endpackage

// File: rtl/div_result_reconstructor_seq_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first,
// accumulator preloaded on start; product is valid in the cycle done is high.
module seq_shift_add_mul
   import div_recon_pkg::*;
#(
   parameter int AW = 8,
   parameter int BW = 8,
   parameter int PW = AW + BW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] a,
   input  logic [BW-1:0] b,
   input  logic [PW-1:0] preload,
   output logic          busy,
   output logic          done,
   output logic [PW-1:0] product
);

   localparam int CW = (BW > 1) ? $clog2(BW) : 1;

   logic [PW-1:0] a_sh;
   logic [PW-1:0] acc;
   logic [PW-1:0] acc_nxt;
   logic [BW-1:0] b_sh;
   logic [CW-1:0] cnt;

   // The last partial product is folded in combinationally so the result is
   // available in the final busy cycle rather than one cycle later.
   assign acc_nxt = b_sh[0] ? acc + a_sh : acc;
   assign done    = busy && (cnt == CW'(BW-1));
   assign product = acc_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         acc  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         a_sh <= PW'(a);
         b_sh <= b;
         acc  <= preload;
         cnt  <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         acc  <= acc_nxt;
         a_sh <= a_sh << 1;
         b_sh <= b_sh >> 1;
         cnt  <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/div_result_reconstructor_seq.sv
// Rebuilds n = q*d + r from a divider's outputs, forms the error and its square,
// and keeps saturating sum-of-squared-error and sample counters.
module div_result_reconstructor_seq
   import div_recon_pkg::*;
#(
   parameter int W     = 8,
   parameter int ACC_W = 48,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*W-1:0]   n,
   input  logic [W-1:0]     d,
   input  logic [W-1:0]     q,
   input  logic [W-1:0]     r,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   n_rec,
   output logic [2*W:0]     err,
   output logic [4*W-1:0]   sq_err,
   output logic             div0,
   input  logic             clear,
   output logic [ACC_W-1:0] sse,
   output logic [CNT_W-1:0] count
);

   localparam int NB = nw_of(W);
   localparam int EB = ew_of(W);
   localparam int SB = sw_of(W);

   state_e        state;
   logic [NB-1:0] n_r;
   logic          div0_r;
   logic [NB-1:0] nrec_p;
   logic [EB-1:0] err_p;

   logic          mul_start, mul_busy, mul_done;
   logic [NB-1:0] mul_p;
   logic          sq_start, sq_busy, sq_done;
   logic [SB-1:0] sq_p;

   logic [EB-1:0] err_c;
   logic [EB-1:0] err_neg;
   logic [NB-1:0] abs_err;

   logic             fire_in, fire_out;
   logic [ACC_W-1:0] sse_base, sse_nxt;
   logic [ACC_W:0]   sse_sum;
   logic [CNT_W-1:0] cnt_base, cnt_nxt;

   assign in_ready  = (state == IDLE) && !mul_busy && !sq_busy;
   assign out_valid = (state == DONE);
   assign fire_in   = in_valid && in_ready;
   assign fire_out  = out_valid && out_ready;

   // The product multiplier reads the ports directly so MUL starts on the
   // acceptance edge; n is kept for the error subtraction.
   assign mul_start = fire_in;

   seq_shift_add_mul #(.AW(W), .BW(W), .PW(NB)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (d),
      .b       (q),
      .preload (NB'(r)),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_p)
   );

   // |err| always fits in 2*W bits: err lies in [-(2^(2W)-1), q*d+r max].
   assign err_c   = {1'b0, mul_p} - {1'b0, n_r};
   assign err_neg = -err_c;
   assign abs_err = err_c[EB-1] ? err_neg[NB-1:0] : err_c[NB-1:0];
   assign sq_start = (state == MUL) && mul_done;

   seq_shift_add_mul #(.AW(NB), .BW(NB), .PW(SB)) u_sqr (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (sq_start),
      .a       (abs_err),
      .b       (abs_err),
      .preload ('0),
      .busy    (sq_busy),
      .done    (sq_done),
      .product (sq_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         n_r    <= '0;
         div0_r <= 1'b0;
         nrec_p <= '0;
         err_p  <= '0;
         n_rec  <= '0;
         err    <= '0;
         sq_err <= '0;
         div0   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (fire_in) begin
               n_r    <= n;
               div0_r <= (d == '0);
               state  <= MUL;
            end
            MUL: if (mul_done) begin
               nrec_p <= mul_p;
               err_p  <= err_c;
               state  <= SQR;
            end
            // Visible outputs change only here, so a discarded sample never leaks out.
            SQR: if (sq_done) begin
               n_rec  <= nrec_p;
               err    <= err_p;
               sq_err <= sq_p;
               div0   <= div0_r;
               state  <= DONE;
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Clear zeroes the base first, so clear with a handshake yields one fresh sample.
   assign sse_base = clear ? '0 : sse;
   assign cnt_base = clear ? '0 : count;
   assign sse_sum  = {1'b0, sse_base} + (ACC_W+1)'(sq_err);
   assign sse_nxt  = sse_sum[ACC_W] ? {ACC_W{1'b1}} : sse_sum[ACC_W-1:0];
   assign cnt_nxt  = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sse   <= '0;
         count <= '0;
      end else if (fire_out) begin
         sse   <= sse_nxt;
         count <= cnt_nxt;
      end else if (clear) begin
         sse   <= '0;
         count <= '0;
      end
   end

endmodule

// File: tb/tb_div_result_reconstructor_seq.sv
// Directed table-driven bench for div_result_reconstructor_seq plus hand-written
// stall, clear, saturation/throughput and mid-operation reset sequences.
module tb_div_result_reconstructor_seq;

   localparam int W = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] n = '0;
   logic [7:0]  d = '0, q = '0, r = '0;

   logic        in_ready, out_valid, div0;
   logic [15:0] n_rec;
   logic [16:0] err;
   logic [31:0] sq_err;
   logic [47:0] sse;
   logic [31:0] count;

   logic        in_ready2, out_valid2, div02;
   logic [15:0] n_rec2;
   logic [16:0] err2;
   logic [31:0] sq_err2;
   logic [32:0] sse2;
   logic [1:0]  count2;

   div_result_reconstructor_seq #(.W(W), .ACC_W(48), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .n(n), .d(d), .q(q), .r(r), .out_valid(out_valid), .out_ready(out_ready),
      .n_rec(n_rec), .err(err), .sq_err(sq_err), .div0(div0), .clear(clear),
      .sse(sse), .count(count)
   );

   // Narrow accumulators so saturation is reachable in a few samples.
   div_result_reconstructor_seq #(.W(W), .ACC_W(33), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .n(n), .d(d), .q(q), .r(r), .out_valid(out_valid2), .out_ready(out_ready),
      .n_rec(n_rec2), .err(err2), .sq_err(sq_err2), .div0(div02), .clear(clear),
      .sse(sse2), .count(count2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_t[$];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (in_valid && in_ready) acc_t.push_back(cyc);

   typedef struct {
      logic [15:0] n;
      logic [7:0]  d, q, r;
      logic [15:0] nrec;
      logic [16:0] err;
      logic [31:0] sq;
      logic        div0;
      logic [47:0] sse;
      logic [31:0] cnt;
   } vec_t;

   vec_t vt[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic accept(input logic [15:0] nn, input logic [7:0] dd, qq, rr);
      int k = 0;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("in_ready_wait", 64'(in_ready), 64'd1);
      n = nn; d = dd; q = qq; r = rr;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Edge index (acceptance edge = 0) at which out_valid is first sampled high.
   task automatic wait_valid(input string tag, input int e0);
      int e = e0;
      do begin
         @(posedge clk);
         e++;
         @(negedge clk);
      end while (!out_valid && e < 60);
      chk({tag, "_latency"}, 64'(e + 1), 64'(3*W + 1));
   endtask

   task automatic handshake(input bit clr);
      out_ready = 1'b1;
      clear = clr;
      @(posedge clk);
      #1 out_ready = 1'b0;
      clear = 1'b0;
   endtask

   initial begin
      logic [32:0] sat2 [4];
      logic [1:0]  cnt2 [4];
      int hs, t;
      bit seen;

      vt[0] = '{16'd1000, 8'd7, 8'd142, 8'd6, 16'd1000, 17'h00000, 32'd0, 1'b0, 48'd0, 32'd1};
      vt[1] = '{16'd1000, 8'd7, 8'd140, 8'd6, 16'd986, 17'h1fff2, 32'd196, 1'b0, 48'd196, 32'd2};
      vt[2] = '{16'd0, 8'd255, 8'd255, 8'd255, 16'd65280, 17'h0ff00, 32'd4261478400, 1'b0,
                48'd4261478596, 32'd3};
      vt[3] = '{16'd50, 8'd0, 8'd9, 8'd3, 16'd3, 17'h1ffd1, 32'd2209, 1'b1, 48'd4261480805, 32'd4};
      vt[4] = '{16'd65535, 8'd0, 8'd0, 8'd0, 16'd0, 17'h10001, 32'd4294836225, 1'b1,
                48'd8556317030, 32'd5};
      sat2 = '{33'd4261478400, 33'd8522956800, 33'h1_ffff_ffff, 33'h1_ffff_ffff};
      cnt2 = '{2'd1, 2'd2, 2'd3, 2'd3};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_n_rec", 64'(n_rec), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_sq_err", 64'(sq_err), 64'd0);
      chk("rst_div0", 64'(div0), 64'd0);
      chk("rst_sse", 64'(sse), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         accept(vt[i].n, vt[i].d, vt[i].q, vt[i].r);
         wait_valid($sformatf("v%0d", i), 0);
         chk($sformatf("v%0d_n_rec", i), 64'(n_rec), 64'(vt[i].nrec));
         chk($sformatf("v%0d_err", i), 64'(err), 64'(vt[i].err));
         chk($sformatf("v%0d_sq_err", i), 64'(sq_err), 64'(vt[i].sq));
         chk($sformatf("v%0d_div0", i), 64'(div0), 64'(vt[i].div0));
         handshake(1'b0);
         chk($sformatf("v%0d_sse", i), 64'(sse), 64'(vt[i].sse));
         chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].cnt));
         chk($sformatf("v%0d_out_valid_drop", i), 64'(out_valid), 64'd0);
      end

      // Clear alone during MUL, then a 10-cycle output stall
      accept(16'd1000, 8'd7, 8'd140, 8'd6);
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      chk("clr_alone_sse", 64'(sse), 64'd0);
      chk("clr_alone_count", 64'(count), 64'd0);
      wait_valid("stall", 1);
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("stall%0d_out_valid", c), 64'(out_valid), 64'd1);
         chk($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
         chk($sformatf("stall%0d_n_rec", c), 64'(n_rec), 64'd986);
         chk($sformatf("stall%0d_sq_err", c), 64'(sq_err), 64'd196);
         chk($sformatf("stall%0d_sse", c), 64'(sse), 64'd0);
         @(negedge clk);
      end
      handshake(1'b0);
      chk("stall_sse", 64'(sse), 64'd196);
      chk("stall_count", 64'(count), 64'd1);

      // Clear coincident with the accept handshake
      accept(16'd1000, 8'd7, 8'd140, 8'd6);
      wait_valid("clracc", 0);
      handshake(1'b1);
      chk("clracc_sse", 64'(sse), 64'd196);
      chk("clracc_count", 64'(count), 64'd1);
      chk("clracc_sse2", 64'(sse2), 64'd196);
      chk("clracc_count2", 64'(count2), 64'd1);

      // Saturation with back-to-back samples and out_ready tied high
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      chk("sat_pre_sse", 64'(sse), 64'd0);
      chk("sat_pre_count2", 64'(count2), 64'd0);
      acc_t.delete();
      @(negedge clk);
      n = 16'd0; d = 8'd255; q = 8'd255; r = 8'd255;
      in_valid = 1'b1;
      out_ready = 1'b1;
      hs = 0;
      t = 0;
      while (hs < 4 && t < 400) begin
         @(negedge clk);
         t++;
         if (out_valid) begin
            hs++;
            @(posedge clk);
            #1;
            if (hs == 4) in_valid = 1'b0;
            chk($sformatf("sat%0d_sse", hs), 64'(sse), 64'(hs) * 64'd4261478400);
            chk($sformatf("sat%0d_count", hs), 64'(count), 64'(hs));
            chk($sformatf("sat%0d_sse2", hs), 64'(sse2), 64'(sat2[hs-1]));
            chk($sformatf("sat%0d_count2", hs), 64'(count2), 64'(cnt2[hs-1]));
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("sat_handshakes", 64'(hs), 64'd4);
      chk("tput_accepts", 64'(acc_t.size()), 64'd4);
      for (int i = 1; i < acc_t.size(); i++)
         chk($sformatf("tput_gap%0d", i), 64'(acc_t[i] - acc_t[i-1]), 64'(3*W + 2));

      // Reset asserted while squaring
      accept(16'd1000, 8'd7, 8'd142, 8'd6);
      repeat (12) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid_out_valid", 64'(out_valid), 64'd0);
      chk("rstmid_in_ready", 64'(in_ready), 64'd1);
      chk("rstmid_sse", 64'(sse), 64'd0);
      chk("rstmid_count", 64'(count), 64'd0);
      chk("rstmid_n_rec", 64'(n_rec), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("rstmid_no_partial", 64'(seen), 64'd0);
      accept(16'd1000, 8'd7, 8'd140, 8'd6);
      wait_valid("post_rst", 0);
      chk("post_rst_n_rec", 64'(n_rec), 64'd986);
      chk("post_rst_err", 64'(err), 64'h1fff2);
      chk("post_rst_sq_err", 64'(sq_err), 64'd196);
      handshake(1'b0);
      chk("post_rst_sse", 64'(sse), 64'd196);
      chk("post_rst_count", 64'(count), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
